booth_mult_n: RTL

BOOTH_MULT_N -- requirements
Module: booth_mult_n

---
 rtl/booth_mult_n.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/booth_mult_n.sv
// booth_mult_n: sequential radix-2 Booth multiplier, one recoding step per cycle.
// Produces the 2*WIDTH-bit product of OpA x OpB on MultHIOut/MultLOOut.
//
// Optional feature macro: BOOTH_MULT_UNSIGNED_EN
//   defined   -> MultSigned selects signed or unsigned operands. Unsigned
//                operands are zero-extended to WIDTH+1 bits and take one
//                extra iteration.
//   undefined -> every operation is signed, MultSigned is ignored, and the
//                datapath stays WIDTH bits wide.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for MultStart; results hold the last product
// RUN   | one Booth add/subtract + arithmetic shift per cycle
// DONE  | final product is registered onto the outputs, MultDone pulses

module booth_mult_n #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             MultStart,
  input  logic             MultSigned,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  output logic             MultBusy,
  output logic             MultDone,
  output logic [WIDTH-1:0] MultHIOut,
  output logic [WIDTH-1:0] MultLOOut
);

`ifdef BOOTH_MULT_UNSIGNED_EN
  localparam int EW = WIDTH + 1;
`else
  localparam int EW = WIDTH;
`endif
  // One guard bit on the partial product so that subtracting the most
  // negative multiplicand cannot overflow.
  localparam int AW = EW + 1;
  // Counter reaches WIDTH (last index of a WIDTH+1 iteration run).
  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [EW-1:0]     mcand;
  logic [AW-1:0]     acc_hi;
  logic [EW-1:0]     acc_lo;
  logic              q_m1;
  logic [CW-1:0]     iter_cnt;

  logic [EW-1:0]     mcand_in;
  logic [EW-1:0]     mplier_in;
  logic [CW-1:0]     last_iter;
  logic [AW-1:0]     mcand_x;
  logic [AW-1:0]     sum;
  logic [AW-1:0]     next_hi;
  logic [EW-1:0]     next_lo;
  logic              next_q;
  logic [AW+EW-1:0]  prod_full;
  logic [2*WIDTH-1:0] product;
  logic              unused_bits;

`ifdef BOOTH_MULT_UNSIGNED_EN
  logic              op_signed;

  // Operand extension: sign bit replicated only for signed operations.
  always_comb begin
    mcand_in  = {MultSigned & OpA[WIDTH-1], OpA};
    mplier_in = {MultSigned & OpB[WIDTH-1], OpB};
  end

  // Signed runs need WIDTH iterations, unsigned runs WIDTH+1.
  always_comb begin
    last_iter = op_signed ? CW'(WIDTH - 1) : CW'(WIDTH);
  end

  // A signed run stops one shift short, so its product sits one bit higher.
  always_comb begin
    prod_full   = {acc_hi, acc_lo};
    product     = op_signed ? prod_full[2*WIDTH:1] : prod_full[2*WIDTH-1:0];
    unused_bits = ^prod_full[AW+EW-1:2*WIDTH+1];
  end
`else
  // Operands are used as-is; everything is treated as two's complement.
  always_comb begin
    mcand_in  = OpA;
    mplier_in = OpB;
  end

  // Fixed iteration count for signed-only operation.
  always_comb begin
    last_iter = CW'(WIDTH - 1);
  end

  // After WIDTH shifts the full product occupies the low 2*WIDTH bits.
  always_comb begin
    prod_full   = {acc_hi, acc_lo};
    product     = prod_full[2*WIDTH-1:0];
    unused_bits = ^{prod_full[AW+EW-1:2*WIDTH], MultSigned};
  end
`endif

  // Booth recoding of the current multiplier bit pair, then arithmetic shift.
  always_comb begin
    mcand_x = {mcand[EW-1], mcand};
    case ({acc_lo[0], q_m1})
      2'b10:   sum = acc_hi - mcand_x;
      2'b01:   sum = acc_hi + mcand_x;
      default: sum = acc_hi;
    endcase
    next_hi = {sum[AW-1], sum[AW-1:1]};
    next_lo = {sum[0], acc_lo[EW-1:1]};
    next_q  = acc_lo[0];
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mcand     <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      q_m1      <= 1'b0;
      iter_cnt  <= '0;
      MultBusy  <= 1'b0;
      MultDone  <= 1'b0;
      MultHIOut <= '0;
      MultLOOut <= '0;
`ifdef BOOTH_MULT_UNSIGNED_EN
      op_signed <= 1'b1;
`endif
    end else begin
      MultDone <= 1'b0;
      case (state)
        IDLE: begin
          if (MultStart) begin
            mcand    <= mcand_in;
            acc_hi   <= '0;
            acc_lo   <= mplier_in;
            q_m1     <= 1'b0;
            iter_cnt <= '0;
            MultBusy <= 1'b1;
            state    <= RUN;
`ifdef BOOTH_MULT_UNSIGNED_EN
            op_signed <= MultSigned;
`endif
          end
        end
        RUN: begin
          acc_hi <= next_hi;
          acc_lo <= next_lo;
          q_m1   <= next_q;
          if (iter_cnt == last_iter) begin
            state <= DONE;
          end else begin
            iter_cnt <= iter_cnt + CW'(1);
          end
        end
        DONE: begin
          MultHIOut <= product[2*WIDTH-1:WIDTH];
          MultLOOut <= product[WIDTH-1:0];
          MultDone  <= 1'b1;
          MultBusy  <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          MultBusy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
